// File: rtl/shift_clk_driver_if.sv
// shift_clk_driver_if: control and serial-output bundle
// for shift_clk_driver (master = requester, slave = driver).
interface shift_clk_driver_if;
   logic        start;
   logic        abort;
   logic [30:0] data_in;
   logic [15:0] half_period;
   logic        shift_clk;
   logic        serial_data;
   logic        busy;
   logic        done;
   logic [5:0]  bit_count;

   modport master (
      output start, abort, data_in, half_period,
      input  shift_clk, serial_data, busy, done, bit_count
   );

   modport slave (
      input  start, abort, data_in, half_period,
      output shift_clk, serial_data, busy, done, bit_count
   );
endinterface

// File: rtl/shift_clk_driver.sv
// shift_clk_driver: serialises a 31-bit word LSB first with a slow
// shift clock. Define SHIFT_DRV_PARITY_EN to append an even-parity bit.
module shift_clk_driver (
   input  logic qzt_clk,
   input  logic reset,
   shift_clk_driver_if.slave bus
);

`ifdef SHIFT_DRV_PARITY_EN
   localparam int N = 32;
`else
   localparam int N = 31;
`endif
   localparam logic [5:0] NBITS = 6'(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   state_t         state;
   logic [N-1:0]   shadow;
   logic [15:0]    cnt;
   logic [15:0]    hm1;
   logic [15:0]    hm1_in;
   logic [N-1:0]   word_in;

   // Half-period minus one; a zero request behaves as one cycle.
   assign hm1_in = (bus.half_period == 16'd0) ?
                   16'd0 : bus.half_period - 16'd1;

`ifdef SHIFT_DRV_PARITY_EN
   assign word_in = {^bus.data_in, bus.data_in};
`else
   assign word_in = bus.data_in;
`endif

   // Transfer FSM: each phase lasts H cycles, all outputs registered.
   always_ff @(posedge qzt_clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         shadow          <= '0;
         cnt             <= '0;
         hm1             <= '0;
         bus.shift_clk   <= 1'b0;
         bus.serial_data <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.bit_count   <= '0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  shadow          <= word_in;
                  hm1             <= hm1_in;
                  cnt             <= hm1_in;
                  bus.serial_data <= bus.data_in[0];
                  bus.busy        <= 1'b1;
                  bus.bit_count   <= '0;
                  state           <= LOW;
               end
            end
            LOW: begin
               if (bus.abort) begin
                  state           <= IDLE;
                  bus.shift_clk   <= 1'b0;
                  bus.serial_data <= 1'b0;
                  bus.busy        <= 1'b0;
               end else if (cnt == 16'd0) begin
                  state         <= HIGH;
                  bus.shift_clk <= 1'b1;
                  bus.bit_count <= bus.bit_count + 6'd1;
                  cnt           <= hm1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            HIGH: begin
               if (bus.abort) begin
                  state           <= IDLE;
                  bus.shift_clk   <= 1'b0;
                  bus.serial_data <= 1'b0;
                  bus.busy        <= 1'b0;
               end else if (cnt == 16'd0) begin
                  bus.shift_clk <= 1'b0;
                  if (bus.bit_count == NBITS) begin
                     state           <= IDLE;
                     bus.serial_data <= 1'b0;
                     bus.busy        <= 1'b0;
                     bus.done        <= 1'b1;
                  end else begin
                     state           <= LOW;
                     shadow          <= {1'b0, shadow[N-1:1]};
                     bus.serial_data <= shadow[1];
                     cnt             <= hm1;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
